fetch_unit: RTL and testbench

- Instruction-fetch front end for the RV32I core. Owns the PC and fetches instruction words from instruction memory over a valid/ready request and valid response handshake.
- Presents the held instruction (op/funct3/funct7 fields plus PC and PC+4) to the decode/control stage.
- Acts on the control stage's PCSrc selection when the downstream datapath retires the instruction.
- It is the consumer end of the PCSrc/ImmExt/ALUResult next-PC interface.

---
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I instruction-fetch front end: PC ownership, imem handshake, retire-driven next-PC
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] instr,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic        instr_valid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    input  logic        retire,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] ImmExt,
    input  logic [31:0] ALUResult,
    output logic        fetch_fault,
    output logic [31:0] retire_count
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_FAULT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic        fetch_fault_q, fetch_fault_d;
    logic [31:0] retire_count_q, retire_count_d;
    logic [31:0] next_pc;

    // PCSrc=11 is not a legal encoding and falls back to sequential fetch.
    always_comb begin
        next_pc = pc_q + 32'd4;
        case (PCSrc)
            2'b01:   next_pc = pc_q + ImmExt;
            2'b10:   next_pc = {ALUResult[31:1], 1'b0};
            default: next_pc = pc_q + 32'd4;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        instr_d        = instr_q;
        instr_valid_d  = instr_valid_q;
        fetch_fault_d  = fetch_fault_q;
        retire_count_d = retire_count_q;
        case (state_q)
            S_BOOT: state_d = S_REQ;
            S_REQ: begin
                if (imem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    instr_d       = imem_resp_data;
                    instr_valid_d = 1'b1;
                    state_d       = S_HOLD;
                end
            end
            S_HOLD: begin
                if (retire) begin
                    pc_d           = next_pc;
                    instr_d        = NOP_INSTR;
                    instr_valid_d  = 1'b0;
                    retire_count_d = retire_count_q + 32'd1;
                    if (next_pc[1:0] != 2'b00) begin
                        fetch_fault_d = 1'b1;
                        state_d       = S_FAULT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_BOOT;
        endcase
    end

    // Reset abandons any outstanding request; a late response is dropped because only S_WAIT consumes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_BOOT;
            pc_q           <= RESET_PC;
            instr_q        <= NOP_INSTR;
            instr_valid_q  <= 1'b0;
            fetch_fault_q  <= 1'b0;
            retire_count_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            instr_q        <= instr_d;
            instr_valid_q  <= instr_valid_d;
            fetch_fault_q  <= fetch_fault_d;
            retire_count_q <= retire_count_d;
        end
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_addr      = pc_q;
    assign instr          = instr_q;
    assign op             = instr_q[6:0];
    assign funct3         = instr_q[14:12];
    assign funct7         = instr_q[31:25];
    assign instr_valid    = instr_valid_q;
    assign PC             = pc_q;
    assign PCPlus4        = pc_q + 32'd4;
    assign fetch_fault    = fetch_fault_q;
    assign retire_count   = retire_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against a transaction-level model
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          N_CYCLES  = 6000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'd0;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        instr_valid;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        retire = 1'b0;
    logic [1:0]  PCSrc = 2'b00;
    logic [31:0] ImmExt = 32'd0;
    logic [31:0] ALUResult = 32'd0;
    logic        fetch_fault;
    logic [31:0] retire_count;

    fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .instr(instr), .op(op), .funct3(funct3), .funct7(funct7), .instr_valid(instr_valid),
        .PC(PC), .PCPlus4(PCPlus4), .retire(retire), .PCSrc(PCSrc), .ImmExt(ImmExt),
        .ALUResult(ALUResult), .fetch_fault(fetch_fault), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[15:0] ^ 16'hA5C3, a[31:16]} ^ 32'h1234_5678;
        return (a == 32'd0) ? 32'h0050_0093 : w;
    endfunction

    // Model state: one instruction is either being requested, in flight, held, or the unit is faulted.
    logic [31:0] m_pc, m_data, m_count, exp_instr, tgt;
    bit          m_booted, m_outstanding, m_held, m_faulted;
    int          rst_cnt, post_rst, fault_cycles;
    bit          exp_req;

    task automatic model_reset();
        m_pc = RESET_PC; m_data = NOP_INSTR; m_count = 32'd0;
        m_booted = 0; m_outstanding = 0; m_held = 0; m_faulted = 0;
        fault_cycles = 0;
    endtask

    initial begin
        int r;
        model_reset();
        rst_cnt = 2;
        post_rst = 0;
        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(negedge clk);
            if (fault_cycles >= 12 && rst_cnt == 0) rst_cnt = 2;
            if (rst_cnt == 0 && cyc > 20 && $urandom_range(0, 299) == 0) rst_cnt = 2;
            if (rst_cnt > 0) begin
                rst_n = 1'b0;
                rst_cnt--;
                model_reset();
                post_rst = 2;
            end else begin
                rst_n = 1'b1;
            end
            #1;
            exp_req   = m_booted && !m_faulted && !m_outstanding && !m_held;
            exp_instr = m_held ? m_data : NOP_INSTR;
            check_eq("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_req});
            if (exp_req) check_eq("imem_addr", imem_addr, m_pc);
            check_eq("pc", PC, m_pc);
            check_eq("pc_plus4", PCPlus4, m_pc + 32'd4);
            check_eq("instr", instr, exp_instr);
            check_eq("op", {25'd0, op}, {25'd0, exp_instr[6:0]});
            check_eq("funct3", {29'd0, funct3}, {29'd0, exp_instr[14:12]});
            check_eq("funct7", {25'd0, funct7}, {25'd0, exp_instr[31:25]});
            check_eq("instr_valid", {31'd0, instr_valid}, {31'd0, m_held});
            check_eq("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_faulted});
            check_eq("retire_count", retire_count, m_count);

            imem_req_ready = ($urandom_range(0, 3) != 0);
            imem_resp_valid = (post_rst > 0) || ($urandom_range(0, 2) == 0);
            imem_resp_data = m_outstanding ? mem_word(m_pc) : $urandom;
            retire = (rst_n == 1'b0) || ($urandom_range(0, 2) == 0);
            PCSrc = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 15);
            if (r == 0) ImmExt = $urandom | 32'd2;
            else ImmExt = (32'($urandom_range(0, 511)) - 32'd256) << 2;
            r = $urandom_range(0, 9);
            if (r == 0) ALUResult = $urandom;
            else if (r == 1) ALUResult = 32'hFFFF_FFFC | 32'($urandom_range(0, 1));
            else ALUResult = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
            if (rst_n) post_rst = (post_rst > 0) ? post_rst - 1 : 0;

            @(posedge clk);
            if (rst_n) begin
                if (!m_booted) begin
                    m_booted = 1;
                end else if (m_faulted) begin
                    fault_cycles++;
                end else if (m_outstanding) begin
                    if (imem_resp_valid) begin
                        m_data = imem_resp_data;
                        m_held = 1;
                        m_outstanding = 0;
                    end
                end else if (m_held) begin
                    if (retire) begin
                        if (PCSrc == 2'b01) tgt = m_pc + ImmExt;
                        else if (PCSrc == 2'b10) tgt = ALUResult & 32'hFFFF_FFFE;
                        else tgt = m_pc + 32'd4;
                        m_pc = tgt;
                        m_count = m_count + 32'd1;
                        m_held = 0;
                        m_data = NOP_INSTR;
                        if (tgt % 4 != 0) m_faulted = 1;
                    end
                end else if (imem_req_ready) begin
                    m_outstanding = 1;
                end
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
